// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
//   dm_state_e : responder FSM states
//   dm_req_t   : latched request payload
//   addr_err() : misaligned / out-of-range decode for a byte address
package dm_pkg;

  localparam int unsigned MAX_LATENCY = 15;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  typedef struct packed {
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dm_req_t;

  // Word access is legal only when aligned and every bit above the word index is zero.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-organised storage with one synchronous read/write port.
//   clk, rst_n : clock, asynchronous active-low clear (all words read as 0 afterwards)
//   en, we     : access strobe, 1 = write / 0 = read
//   addr       : word index
//   wdata, be  : write data and per-byte-lane enables
//   rdata      : registered read data, updated only by read accesses
module dm_ram
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // The array itself is not reset; a per-word valid bit makes a cleared word read as zero.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] word_c, merged_c;

  // Current word, byte-lane merge and read/valid updates.
  always_comb begin
    word_c   = vld_q[addr] ? mem_q[addr] : '0;
    merged_c = word_c;
    for (int b = 0; b < int'(BE_W); b++) begin
      if (be[b]) merged_c[8*b +: 8] = wdata[8*b +: 8];
    end
    vld_d   = vld_q;
    rdata_d = rdata_q;
    if (en) begin
      if (we) vld_d[addr] = 1'b1;
      else    rdata_d     = word_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      rdata_q <= '0;
    end else begin
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (en && we) mem_q[addr] <= merged_c;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Handshaked data-memory responder: one load/store in flight, fixed latency.
//   clk, reset           : clock, asynchronous active-low reset (release synchronised)
//   req_valid/req_ready  : request handshake; req_ready decoded from state
//   req_we/addr/wdata/be : request payload, sampled on acceptance
//   resp_valid/ready     : response handshake
//   resp_rdata, resp_err : load data (0 for stores/errors), error flag
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  // Out-of-range latencies are clamped into 1..MAX_LATENCY.
  localparam int unsigned LAT_C =
    (LATENCY > MAX_LATENCY) ? MAX_LATENCY : ((LATENCY < 1) ? 1 : LATENCY);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(LAT_C - 1);
  localparam logic             ONE_CYCLE = (LAT_C == 1);

  logic              rst_sync_q;
  dm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dm_req_t           req_q, req_d, cur_c;
  logic              err_q, err_d;
  logic              rd_ok_q, rd_ok_d;
  logic              acc_c, acc_err_c, ram_en_c;
  logic [DATA_W-1:0] ram_rdata;

  // Asserts asynchronously, releases on the first clock edge after reset deasserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  // Access decode: in IDLE the incoming request feeds the access directly (one-cycle latency).
  always_comb begin
    cur_c = req_q;
    if (state_q == IDLE) begin
      cur_c = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
    end
    acc_c = ((state_q == IDLE) && req_valid && ONE_CYCLE) ||
            ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
    acc_err_c = addr_err(cur_c.addr, ADDR_W);
    ram_en_c  = acc_c && !acc_err_c;
  end

  // Next-state, counter, request latch and response flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    rd_ok_d = rd_ok_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d   = cur_c;
          cnt_d   = CNT_INIT;
          state_d = ONE_CYCLE ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
          rd_ok_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (acc_c) begin
      err_d   = acc_err_c;
      rd_ok_d = !acc_err_c && !cur_c.we;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  dm_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_sync_q),
    .en    (ram_en_c),
    .we    (cur_c.we),
    .addr  (cur_c.addr[ADDR_W+1:2]),
    .wdata (cur_c.wdata),
    .be    (cur_c.be),
    .rdata (ram_rdata)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = err_q;
  // RAM read register only changes on load accesses; the flag zeroes it for stores/errors.
  assign resp_rdata = rd_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_dm_responder;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid_1, req_ready_1, req_we_1;
  logic [31:0] req_addr_1, req_wdata_1;
  logic [3:0]  req_be_1;
  logic        resp_valid_1, resp_ready_1, resp_err_1;
  logic [31:0] resp_rdata_1;

  int n_checks = 0;
  int n_errors = 0;

  dm_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dm_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_we(req_we_1),
    .req_addr(req_addr_1), .req_wdata(req_wdata_1), .req_be(req_be_1),
    .resp_valid(resp_valid_1), .resp_ready(resp_ready_1),
    .resp_rdata(resp_rdata_1), .resp_err(resp_err_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance, starting and ending at a negedge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rdata, output logic err,
                     output int lat);
    int t;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1; resp_ready = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    txn(we, addr, wdata, be, rd, er, lat);
    check({tag, "_rdata"}, rd, exp_rdata);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
    check({tag, "_lat"}, 32'(lat), 32'd2);
  endtask

  initial begin
    int   t;
    time  acc_t, prev_t;
    logic [31:0] l1_data [4];
    l1_data[0] = 32'hA0A0_0001; l1_data[1] = 32'hB1B1_0002;
    l1_data[2] = 32'hC2C2_0003; l1_data[3] = 32'hD3D3_0004;

    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    resp_ready = 1'b1;
    req_valid_1 = 1'b0; req_we_1 = 1'b0; req_addr_1 = '0; req_wdata_1 = '0; req_be_1 = '0;
    resp_ready_1 = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Store then load.
    chk_txn("st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
    chk_txn("ld10", 1'b0, 32'h0000_0010, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // Byte enables.
    chk_txn("st20a", 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'd0, 1'b0);
    chk_txn("st20b", 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0);
    chk_txn("ld20b", 1'b0, 32'h0000_0020, 32'd0, 4'hF, 32'h11BB_33DD, 1'b0);
    chk_txn("st20z", 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0);
    chk_txn("ld20z", 1'b0, 32'h0000_0020, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0);

    // Last word and error cases.
    chk_txn("stlast", 1'b1, 32'h0000_0FFC, 32'h0F0F_1234, 4'hF, 32'd0, 1'b0);
    chk_txn("ldlast", 1'b0, 32'h0000_0FFC, 32'd0, 4'h0, 32'h0F0F_1234, 1'b0);
    chk_txn("ldmis", 1'b0, 32'h0000_0002, 32'd0, 4'h0, 32'd0, 1'b1);
    chk_txn("st0", 1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'd0, 1'b0);
    chk_txn("stoor", 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b1);
    chk_txn("ld0", 1'b0, 32'h0000_0000, 32'd0, 4'h0, 32'h1234_5678, 1'b0);
    chk_txn("ldoor", 1'b0, 32'h8000_0010, 32'd0, 4'h0, 32'd0, 1'b1);

    // Backpressure: load 0x10 held in RESP while a store request waits.
    req_we = 1'b0; req_addr = 32'h0000_0010; req_be = 4'h0;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h0000_0044; req_wdata = 32'h0000_0055; req_be = 4'hF;
    t = 0;
    while (!resp_valid && t < 20) begin @(negedge clk); t++; end
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, 32'hDEAD_BEEF);
      check("bp_err", 32'(resp_err), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_post_valid", 32'(resp_valid), 32'd0);
    check("bp_post_rdata", resp_rdata, 32'd0);
    check("bp_post_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_held_ready", 32'(req_ready), 32'd0);
    t = 0;
    while (!resp_valid && t < 20) begin @(negedge clk); t++; end
    check("bp_held_valid", 32'(resp_valid), 32'd1);
    check("bp_held_err", 32'(resp_err), 32'd0);
    check("bp_held_rdata", resp_rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk_txn("ld44", 1'b0, 32'h0000_0044, 32'd0, 4'h0, 32'h0000_0055, 1'b0);

    // Reset during WAIT of a store to 0x30.
    req_we = 1'b1; req_addr = 32'h0000_0030; req_wdata = 32'h0000_0077; req_be = 4'hF;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_ready_wait", 32'(req_ready), 32'd0);
    #1 reset = 1'b0;
    #1;
    check("mid_ready_rst", 32'(req_ready), 32'd1);
    check("mid_valid_rst", 32'(resp_valid), 32'd0);
    check("mid_rdata_rst", resp_rdata, 32'd0);
    check("mid_err_rst", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_txn("ld30", 1'b0, 32'h0000_0030, 32'd0, 4'h0, 32'd0, 1'b0);
    chk_txn("ld10r", 1'b0, 32'h0000_0010, 32'd0, 4'h0, 32'd0, 1'b0);

    // LATENCY=1: four stores then four loads with request valid held high.
    prev_t = 0;
    for (int i = 0; i < 8; i++) begin
      req_we_1    = (i < 4);
      req_addr_1  = 32'h0000_0100 + 32'(4 * (i % 4));
      req_wdata_1 = (i < 4) ? l1_data[i % 4] : 32'd0;
      req_be_1    = 4'hF;
      req_valid_1 = 1'b1;
      t = 0;
      while (!req_ready_1 && t < 10) begin @(negedge clk); t++; end
      if (!req_ready_1) check("l1_accept_timeout", 32'(req_ready_1), 32'd1);
      @(posedge clk);
      acc_t = $time;
      @(negedge clk);
      if (i > 0) check("l1_rate", 32'((acc_t - prev_t) / 10), 32'd2);
      prev_t = acc_t;
      check("l1_valid", 32'(resp_valid_1), 32'd1);
      check("l1_err", 32'(resp_err_1), 32'd0);
      check("l1_rdata", resp_rdata_1, (i < 4) ? 32'd0 : l1_data[i % 4]);
    end
    req_valid_1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("l1_idle_valid", 32'(resp_valid_1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
